pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Next-generation control unit for the 5-stage MIPS pipeline. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also owns the pipeline-control decisions: load-use stall, taken-branch flush, and whole-pipe freeze while data memory is busy. It drives per-stage control to the datapath and keeps a saturating stall-cycle counter.

Parameters:
OPCODE_WIDTH, 6, opcode field width
REG_ADDR_WIDTH, 5, register-address width
ALUOP_WIDTH, 2, ALUOp field width
CNT_WIDTH, 16, stall-counter width

Ports:
d_clk  in  1  clock
d_rst_n  in  1  async active-low reset
i_id_valid  in  1  ID holds a real instruction
i_id_opcode  in  OPCODE_WIDTH  ID opcode
i_id_rs / i_id_rt / i_id_rd  in  REG_ADDR_WIDTH each  ID register fields
i_ex_branch_taken  in  1  branch in EX resolved taken
i_mem_ready  in  1  data-memory access completes this cycle
o_pc_stall / o_ifid_stall / o_ifid_flush  out  1 each  front-end control
o_ex_valid, o_ex_alusrc, o_ex_branch, o_ex_bne  out  1 each  EX control
o_ex_aluop  out  ALUOP_WIDTH  EX ALU operation class
o_mem_valid, o_mem_read, o_mem_write  out  1 each  MEM control
o_wb_valid, o_wb_regwrite, o_wb_memtoreg  out  1 each  WB control
o_wb_waddr  out  REG_ADDR_WIDTH  write-back register
o_illegal  out  1  registered one-cycle pulse: invalid opcode entered EX
o_stall_count  out  CNT_WIDTH  load-use stall cycles, saturating

Behaviour:
- Reset is asynchronous and active-low on d_rst_n, clocked on rising d_clk. Reset clears every stage register and the counter, so every output is 0.
- Decode table (used when i_id_valid=1):
  - RTYPE: regdst=1, regwrite=1, aluop=10.
  - BEQ/BNE: branch=1, aluop=01; bne=1 for BNE only.
  - ADDI/ADDIU: alusrc=1, regwrite=1, aluop=00.
  - SLTI/SLTIU/ANDI/ORI/XORI: alusrc=1, regwrite=1, aluop=11.
  - LOAD: alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=00.
  - STORE: alusrc=1, memwrite=1, aluop=00.
  - Any other opcode: all controls 0, and the illegal flag is latched into ID/EX.
- Destination register is resolved at the ID->EX latch: waddr = regdst ? rd : rt. It travels with the bundle. At WB, regwrite is forced to 0 when waddr=0.
- rt is a source for RTYPE, BEQ, BNE and STORE only.
- Latency: ID decode appears on o_ex_* 1 cycle later, on o_mem_* 2 cycles later, on o_wb_* 3 cycles later.
- freeze = o_mem_valid & (o_mem_read | o_mem_write) & !i_mem_ready. While freeze:
  - ID/EX and EX/MEM hold, MEM/WB loads a bubble (valid=0, controls 0).
  - o_pc_stall=1, o_ifid_stall=1, o_ifid_flush=0.
  - i_ex_branch_taken is ignored; the branch stays in EX and acts after release.
- flush = !freeze & i_ex_branch_taken:
  - o_ifid_flush=1, and ID/EX loads a bubble.
  - Load-use stall is suppressed; the counter does not increment.
- loaduse = !freeze & !flush & i_id_valid & o_ex_valid & o_mem_read_ex(internal) & ex_waddr≠0 & (ex_waddr==rs | (rt used & ex_waddr==rt)):
  - o_pc_stall=1, o_ifid_stall=1, ID/EX loads a bubble.
  - EX/MEM and MEM/WB advance normally.
  - o_stall_count increments by 1 and saturates at all-ones.
- Priority: freeze > flush > loaduse > normal advance. All front-end outputs are combinational from current state and inputs.
- Bubbles carry valid=0 and all controls 0; o_illegal is 0 for a bubble.
- Reset asserted mid-operation clears all stages immediately, including a pending freeze.

Decomposition:
- Shared header holds opcode constants (RTYPE, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LOAD, STORE) and ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_IMM=11).
- One combinational sub-module, ctrl_decode (opcode -> bundle + illegal). pipe_ctrl_unit instantiates it and holds the stage registers, hazard logic and counter.

Test Plan:
- Reset, then RTYPE rs=1 rt=2 rd=3 -> o_ex_aluop=10 at +1; o_wb_regwrite=1, o_wb_waddr=3 at +3.
- LOAD rt=5, then ADD rs=5 -> stall exactly 1 cycle, EX bubble (o_ex_valid=0), o_stall_count=1; the ADD proceeds the next cycle.
- LOAD rt=5, then ADDI rt=5 rs=4 -> no stall (rt not a source); LOAD to $0 followed by a $0 use -> no stall, o_wb_regwrite=0.
- BEQ in EX with i_ex_branch_taken=1 and a load-use condition present simultaneously -> o_ifid_flush=1, ID/EX bubble, o_stall_count unchanged.
- STORE in MEM with i_mem_ready low for 3 cycles and taken branch in EX -> 3 frozen cycles, 3 WB bubbles, no flush; flush occurs on the cycle after i_mem_ready=1.
- Opcode 6'h3F -> o_illegal pulses 1 cycle with all controls 0; reset asserted mid-freeze -> all outputs 0 asynchronously; CNT_WIDTH=2 with 5 stalls -> count saturates at 3.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control unit: MIPS opcode constants,
// ALUOp classes and the control bundles carried through the stage registers.
package pipe_ctrl_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } aluop_e;

    // Everything the ID/EX register carries (regdst is consumed at the latch).
    typedef struct packed {
        logic   alusrc;
        logic   branch;
        logic   bne;
        aluop_e aluop;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   regwrite;
    } ex_ctrl_t;

    // Subset that survives into EX/MEM.
    typedef struct packed {
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } mem_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode: purely combinational opcode decoder.
//   opcode  : ID-stage opcode
//   ctrl    : control bundle for the ID/EX register
//   regdst  : destination is rd (1) or rt (0)
//   rt_used : rt is a source operand (used by the load-use check)
//   illegal : opcode is not in the decode table
module ctrl_decode
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output ex_ctrl_t                ctrl,
    output logic                    regdst,
    output logic                    rt_used,
    output logic                    illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ctrl    = '0;
        regdst  = 1'b0;
        rt_used = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPCODE_WIDTH'(OP_RTYPE): begin
                regdst        = 1'b1;
                rt_used       = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_FUNCT;
            end
            OPCODE_WIDTH'(OP_BEQ), OPCODE_WIDTH'(OP_BNE): begin
                rt_used     = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.bne    = (opcode == OPCODE_WIDTH'(OP_BNE));
                ctrl.aluop  = ALUOP_SUB;
            end
            OPCODE_WIDTH'(OP_ADDI), OPCODE_WIDTH'(OP_ADDIU): begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OPCODE_WIDTH'(OP_SLTI), OPCODE_WIDTH'(OP_SLTIU), OPCODE_WIDTH'(OP_ANDI),
            OPCODE_WIDTH'(OP_ORI), OPCODE_WIDTH'(OP_XORI): begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_IMM;
            end
            OPCODE_WIDTH'(OP_LOAD): begin
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OPCODE_WIDTH'(OP_STORE): begin
                rt_used       = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control path of a 5-stage MIPS pipeline.
// Decodes the ID opcode, carries the control bundle through ID/EX, EX/MEM and
// MEM/WB, and resolves freeze (memory busy), branch flush and load-use stall.
//   d_clk, d_rst_n          : clock, asynchronous active-low reset
//   i_id_*                  : instruction currently in ID
//   i_ex_branch_taken       : branch in EX resolved taken
//   i_mem_ready             : data-memory access completes this cycle
//   o_pc_stall/o_ifid_*     : front-end control (combinational)
//   o_ex_* / o_mem_* / o_wb_*: per-stage registered control
//   o_illegal               : one-cycle pulse when an invalid opcode enters EX
//   o_stall_count           : saturating count of load-use stall cycles
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      d_clk,
    input  logic                      d_rst_n,
    input  logic                      i_id_valid,
    input  logic [OPCODE_WIDTH-1:0]   i_id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
    input  logic                      i_ex_branch_taken,
    input  logic                      i_mem_ready,
    output logic                      o_pc_stall,
    output logic                      o_ifid_stall,
    output logic                      o_ifid_flush,
    output logic                      o_ex_valid,
    output logic                      o_ex_alusrc,
    output logic                      o_ex_branch,
    output logic                      o_ex_bne,
    output logic [ALUOP_WIDTH-1:0]    o_ex_aluop,
    output logic                      o_mem_valid,
    output logic                      o_mem_read,
    output logic                      o_mem_write,
    output logic                      o_wb_valid,
    output logic                      o_wb_regwrite,
    output logic                      o_wb_memtoreg,
    output logic [REG_ADDR_WIDTH-1:0] o_wb_waddr,
    output logic                      o_illegal,
    output logic [CNT_WIDTH-1:0]      o_stall_count
);

    ex_ctrl_t dec_ctrl;
    logic     dec_regdst;
    logic     dec_rt_used;
    logic     dec_illegal;

    ctrl_decode #(
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_decode (
        .opcode (i_id_opcode),
        .ctrl   (dec_ctrl),
        .regdst (dec_regdst),
        .rt_used(dec_rt_used),
        .illegal(dec_illegal)
    );

    // Stage registers
    logic                      ex_valid;
    ex_ctrl_t                  ex_ctrl;
    logic [REG_ADDR_WIDTH-1:0] ex_waddr;
    logic                      illegal_q;

    logic                      mem_valid;
    mem_ctrl_t                 mem_ctrl;
    logic [REG_ADDR_WIDTH-1:0] mem_waddr;

    logic                      wb_valid;
    logic                      wb_regwrite;
    logic                      wb_memtoreg;
    logic [REG_ADDR_WIDTH-1:0] wb_waddr;

    logic [CNT_WIDTH-1:0]      stall_count;

    // Hazard resolution, in priority order freeze > flush > loaduse.
    logic freeze, flush, loaduse, ex_dep, id_load;

    assign freeze  = mem_valid & (mem_ctrl.memread | mem_ctrl.memwrite) & ~i_mem_ready;
    // A taken branch waits out a freeze in EX and acts once memory releases.
    assign flush   = ~freeze & i_ex_branch_taken;
    assign ex_dep  = (ex_waddr == i_id_rs) | (dec_rt_used & (ex_waddr == i_id_rt));
    assign loaduse = ~freeze & ~flush & i_id_valid & ex_valid & ex_ctrl.memread
                   & (ex_waddr != '0) & ex_dep;
    assign id_load = ~flush & ~loaduse & i_id_valid;

    // ID/EX: hold on freeze, bubble on flush/loaduse/empty ID, else latch decode.
    always_ff @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_waddr  <= '0;
            illegal_q <= 1'b0;
        end else if (freeze) begin
            // The held instruction already reported itself; keep the flag a single pulse.
            illegal_q <= 1'b0;
        end else if (id_load) begin
            ex_valid  <= 1'b1;
            ex_ctrl   <= dec_ctrl;
            ex_waddr  <= dec_regdst ? i_id_rd : i_id_rt;
            illegal_q <= dec_illegal;
        end else begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_waddr  <= '0;
            illegal_q <= 1'b0;
        end
    end

    // EX/MEM: holds during freeze, otherwise advances.
    always_ff @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_waddr <= '0;
        end else if (!freeze) begin
            mem_valid <= ex_valid;
            mem_ctrl  <= '{memread:  ex_ctrl.memread,
                           memwrite: ex_ctrl.memwrite,
                           memtoreg: ex_ctrl.memtoreg,
                           regwrite: ex_ctrl.regwrite};
            mem_waddr <= ex_waddr;
        end
    end

    // MEM/WB: bubble during freeze; writes to $0 are suppressed here.
    always_ff @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_waddr    <= '0;
        end else if (freeze) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_waddr    <= '0;
        end else begin
            wb_valid    <= mem_valid;
            wb_regwrite <= mem_ctrl.regwrite & (mem_waddr != '0);
            wb_memtoreg <= mem_ctrl.memtoreg;
            wb_waddr    <= mem_waddr;
        end
    end

    always_ff @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            stall_count <= '0;
        end else if (loaduse && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign o_pc_stall    = freeze | loaduse;
    assign o_ifid_stall  = freeze | loaduse;
    assign o_ifid_flush  = flush;

    assign o_ex_valid    = ex_valid;
    assign o_ex_alusrc   = ex_ctrl.alusrc;
    assign o_ex_branch   = ex_ctrl.branch;
    assign o_ex_bne      = ex_ctrl.bne;
    assign o_ex_aluop    = ALUOP_WIDTH'(ex_ctrl.aluop);

    assign o_mem_valid   = mem_valid;
    assign o_mem_read    = mem_ctrl.memread;
    assign o_mem_write   = mem_ctrl.memwrite;

    assign o_wb_valid    = wb_valid;
    assign o_wb_regwrite = wb_regwrite;
    assign o_wb_memtoreg = wb_memtoreg;
    assign o_wb_waddr    = wb_waddr;

    assign o_illegal     = illegal_q;
    assign o_stall_count = stall_count;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit. An instruction-level pipeline model (which
// instruction sits in EX/MEM/WB) derives every expected output each cycle;
// directed literal checks pin the model at the interesting points. A second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_pipe_ctrl_unit;

    localparam logic [5:0] RT   = 6'h00;
    localparam logic [5:0] BEQ  = 6'h04;
    localparam logic [5:0] BNE  = 6'h05;
    localparam logic [5:0] ADDI = 6'h08;
    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] SW   = 6'h2B;
    localparam logic [5:0] ILL  = 6'h3F;

    logic       d_clk = 1'b0;
    logic       d_rst_n;
    logic       i_id_valid;
    logic [5:0] i_id_opcode;
    logic [4:0] i_id_rs, i_id_rt, i_id_rd;
    logic       i_ex_branch_taken;
    logic       i_mem_ready;

    logic        o_pc_stall, o_ifid_stall, o_ifid_flush;
    logic        o_ex_valid, o_ex_alusrc, o_ex_branch, o_ex_bne;
    logic [1:0]  o_ex_aluop;
    logic        o_mem_valid, o_mem_read, o_mem_write;
    logic        o_wb_valid, o_wb_regwrite, o_wb_memtoreg;
    logic [4:0]  o_wb_waddr;
    logic        o_illegal;
    logic [15:0] o_stall_count;

    logic        s_pc_stall, s_ifid_stall, s_ifid_flush;
    logic        s_ex_valid, s_ex_alusrc, s_ex_branch, s_ex_bne;
    logic [1:0]  s_ex_aluop;
    logic        s_mem_valid, s_mem_read, s_mem_write;
    logic        s_wb_valid, s_wb_regwrite, s_wb_memtoreg;
    logic [4:0]  s_wb_waddr;
    logic        s_illegal;
    logic [1:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 d_clk = ~d_clk;

    pipe_ctrl_unit dut (
        .d_clk(d_clk), .d_rst_n(d_rst_n),
        .i_id_valid(i_id_valid), .i_id_opcode(i_id_opcode),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_rd(i_id_rd),
        .i_ex_branch_taken(i_ex_branch_taken), .i_mem_ready(i_mem_ready),
        .o_pc_stall(o_pc_stall), .o_ifid_stall(o_ifid_stall), .o_ifid_flush(o_ifid_flush),
        .o_ex_valid(o_ex_valid), .o_ex_alusrc(o_ex_alusrc), .o_ex_branch(o_ex_branch),
        .o_ex_bne(o_ex_bne), .o_ex_aluop(o_ex_aluop),
        .o_mem_valid(o_mem_valid), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_wb_valid(o_wb_valid), .o_wb_regwrite(o_wb_regwrite), .o_wb_memtoreg(o_wb_memtoreg),
        .o_wb_waddr(o_wb_waddr), .o_illegal(o_illegal), .o_stall_count(o_stall_count)
    );

    pipe_ctrl_unit #(.CNT_WIDTH(2)) dut_small (
        .d_clk(d_clk), .d_rst_n(d_rst_n),
        .i_id_valid(i_id_valid), .i_id_opcode(i_id_opcode),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_rd(i_id_rd),
        .i_ex_branch_taken(i_ex_branch_taken), .i_mem_ready(i_mem_ready),
        .o_pc_stall(s_pc_stall), .o_ifid_stall(s_ifid_stall), .o_ifid_flush(s_ifid_flush),
        .o_ex_valid(s_ex_valid), .o_ex_alusrc(s_ex_alusrc), .o_ex_branch(s_ex_branch),
        .o_ex_bne(s_ex_bne), .o_ex_aluop(s_ex_aluop),
        .o_mem_valid(s_mem_valid), .o_mem_read(s_mem_read), .o_mem_write(s_mem_write),
        .o_wb_valid(s_wb_valid), .o_wb_regwrite(s_wb_regwrite), .o_wb_memtoreg(s_wb_memtoreg),
        .o_wb_waddr(s_wb_waddr), .o_illegal(s_illegal), .o_stall_count(s_stall_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    logic m_ill;
    int   m_stalls;

    function automatic logic is_immalu(input logic [5:0] op);
        return op inside {6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
    endfunction
    function automatic logic is_addi(input logic [5:0] op);
        return op inside {6'h08, 6'h09};
    endfunction
    function automatic logic is_branch(input logic [5:0] op);
        return op == BEQ || op == BNE;
    endfunction
    function automatic logic legal(input logic [5:0] op);
        return op == RT || is_branch(op) || is_addi(op) || is_immalu(op) || op == LW || op == SW;
    endfunction
    function automatic logic writes(input logic [5:0] op);
        return op == RT || is_addi(op) || is_immalu(op) || op == LW;
    endfunction
    function automatic logic [4:0] dest(input ins_t i);
        return (i.op == RT) ? i.rd : i.rt;
    endfunction
    function automatic logic rt_src(input logic [5:0] op);
        return op == RT || is_branch(op) || op == SW;
    endfunction

    function automatic logic m_freeze();
        return m_mem.v && (m_mem.op == LW || m_mem.op == SW) && !i_mem_ready;
    endfunction
    function automatic logic m_flush();
        return !m_freeze() && i_ex_branch_taken;
    endfunction
    function automatic logic m_loaduse();
        logic [4:0] w;
        w = dest(m_ex);
        return !m_freeze() && !m_flush() && i_id_valid && m_ex.v && m_ex.op == LW && w != 0 &&
               (w == i_id_rs || (rt_src(i_id_opcode) && w == i_id_rt));
    endfunction

    always @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0; m_stalls = 0;
        end else begin
            logic fz, fl, lu;
            fz = m_freeze(); fl = m_flush(); lu = m_loaduse();
            if (fz) begin
                m_wb  = '0;
                m_ill = 1'b0;
            end else begin
                m_wb  = m_mem;
                m_mem = m_ex;
                if (fl || lu || !i_id_valid) m_ex = '0;
                else m_ex = '{1'b1, i_id_opcode, i_id_rs, i_id_rt, i_id_rd};
                m_ill = m_ex.v && !legal(m_ex.op);
                if (lu) m_stalls++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge d_clk) begin
        logic [1:0] aop;
        logic       stall;
        aop = !m_ex.v ? 2'b00 : (m_ex.op == RT) ? 2'b10 : is_branch(m_ex.op) ? 2'b01 :
              is_immalu(m_ex.op) ? 2'b11 : 2'b00;
        stall = m_freeze() || m_loaduse();
        check("pc_stall",   o_pc_stall,   stall);
        check("ifid_stall", o_ifid_stall, stall);
        check("ifid_flush", o_ifid_flush, m_flush());
        check("ex_valid",   o_ex_valid,   m_ex.v);
        check("ex_alusrc",  o_ex_alusrc,  m_ex.v && (is_addi(m_ex.op) || is_immalu(m_ex.op) ||
                                                     m_ex.op == LW || m_ex.op == SW));
        check("ex_branch",  o_ex_branch,  m_ex.v && is_branch(m_ex.op));
        check("ex_bne",     o_ex_bne,     m_ex.v && m_ex.op == BNE);
        check("ex_aluop",   o_ex_aluop,   aop);
        check("mem_valid",  o_mem_valid,  m_mem.v);
        check("mem_read",   o_mem_read,   m_mem.v && m_mem.op == LW);
        check("mem_write",  o_mem_write,  m_mem.v && m_mem.op == SW);
        check("wb_valid",   o_wb_valid,   m_wb.v);
        check("wb_regwrite", o_wb_regwrite, m_wb.v && writes(m_wb.op) && dest(m_wb) != 0);
        check("wb_memtoreg", o_wb_memtoreg, m_wb.v && m_wb.op == LW);
        check("wb_waddr",   o_wb_waddr,   m_wb.v ? dest(m_wb) : 5'd0);
        check("illegal",    o_illegal,    m_ill);
        check("stall_count", o_stall_count, (m_stalls > 65535) ? 65535 : m_stalls);
        check("stall_count_w2", s_stall_count, (m_stalls > 3) ? 3 : m_stalls);
    end

    // ---------------- stimulus ----------------
    task automatic id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd);
        i_id_valid = 1'b1; i_id_opcode = op; i_id_rs = rs; i_id_rt = rt; i_id_rd = rd;
    endtask
    task automatic idle();
        i_id_valid = 1'b0; i_id_opcode = '0; i_id_rs = '0; i_id_rt = '0; i_id_rd = '0;
    endtask
    task automatic tick();
        @(posedge d_clk);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    task automatic check_all_zero(input string name);
        check(name, {o_pc_stall, o_ifid_stall, o_ifid_flush, o_ex_valid, o_ex_alusrc,
                     o_ex_branch, o_ex_bne, o_ex_aluop, o_mem_valid, o_mem_read, o_mem_write,
                     o_wb_valid, o_wb_regwrite, o_wb_memtoreg, o_wb_waddr, o_illegal}, 32'd0);
        check({name, "_cnt"}, o_stall_count, 32'd0);
    endtask

    initial begin
        d_rst_n = 1'b0;
        idle();
        i_ex_branch_taken = 1'b0;
        i_mem_ready = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge d_clk);
        #1 d_rst_n = 1'b1;

        // RTYPE rs=1 rt=2 rd=3: EX at +1, WB at +3.
        id(RT, 5'd1, 5'd2, 5'd3);
        tick();
        idle();
        check("rtype_ex_aluop", o_ex_aluop, 2'b10);
        check("rtype_ex_valid", o_ex_valid, 1'b1);
        tick();
        tick();
        check("rtype_wb_regwrite", o_wb_regwrite, 1'b1);
        check("rtype_wb_waddr", o_wb_waddr, 5'd3);

        // LW $5 then ADD using $5 as rs: exactly one stall.
        id(LW, 5'd0, 5'd5, 5'd0);
        tick();
        id(RT, 5'd5, 5'd6, 5'd7);
        settle();
        check("lu_pc_stall", o_pc_stall, 1'b1);
        check("lu_ifid_stall", o_ifid_stall, 1'b1);
        tick();
        check("lu_ex_bubble", o_ex_valid, 1'b0);
        check("lu_count", o_stall_count, 16'd1);
        check("lu_released", o_pc_stall, 1'b0);
        tick();
        check("lu_add_ex", o_ex_valid, 1'b1);
        check("lu_add_aluop", o_ex_aluop, 2'b10);

        // LW $5 then ADDI writing $5: rt is not a source, no stall.
        id(LW, 5'd0, 5'd5, 5'd0);
        tick();
        id(ADDI, 5'd4, 5'd5, 5'd0);
        settle();
        check("addi_no_stall", o_pc_stall, 1'b0);
        tick();
        check("addi_ex_valid", o_ex_valid, 1'b1);
        check("addi_count", o_stall_count, 16'd1);

        // LW $0 then a $0 use: no stall, and the load does not write back.
        id(LW, 5'd0, 5'd0, 5'd0);
        tick();
        id(RT, 5'd0, 5'd0, 5'd8);
        settle();
        check("zero_no_stall", o_pc_stall, 1'b0);
        tick();
        idle();
        tick();
        check("zero_wb_valid", o_wb_valid, 1'b1);
        check("zero_wb_regwrite", o_wb_regwrite, 1'b0);

        // Taken-branch indication coincident with a load-use condition: flush wins.
        id(LW, 5'd0, 5'd5, 5'd0);
        tick();
        id(RT, 5'd5, 5'd6, 5'd7);
        i_ex_branch_taken = 1'b1;
        settle();
        check("prio_flush", o_ifid_flush, 1'b1);
        check("prio_no_stall", o_pc_stall, 1'b0);
        tick();
        i_ex_branch_taken = 1'b0;
        check("prio_ex_bubble", o_ex_valid, 1'b0);
        check("prio_count", o_stall_count, 16'd1);
        tick();
        idle();

        // BEQ resolved taken in EX.
        id(BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        check("beq_branch", o_ex_branch, 1'b1);
        check("beq_aluop", o_ex_aluop, 2'b01);
        id(ADDI, 5'd1, 5'd3, 5'd0);
        i_ex_branch_taken = 1'b1;
        settle();
        check("beq_flush", o_ifid_flush, 1'b1);
        tick();
        i_ex_branch_taken = 1'b0;
        check("beq_ex_bubble", o_ex_valid, 1'b0);
        idle();
        tick();

        // STORE in MEM, memory busy 3 cycles, taken branch waiting in EX.
        id(SW, 5'd1, 5'd2, 5'd0);
        tick();
        id(BNE, 5'd1, 5'd2, 5'd0);
        tick();
        id(ADDI, 5'd1, 5'd9, 5'd0);
        i_mem_ready = 1'b0;
        i_ex_branch_taken = 1'b1;
        settle();
        check("frz_pc_stall", o_pc_stall, 1'b1);
        check("frz_no_flush", o_ifid_flush, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz_wb_bubble", o_wb_valid, 1'b0);
            check("frz_mem_hold", o_mem_write, 1'b1);
            check("frz_ex_hold", o_ex_bne, 1'b1);
        end
        i_mem_ready = 1'b1;
        settle();
        check("frz_release_flush", o_ifid_flush, 1'b1);
        check("frz_release_stall", o_pc_stall, 1'b0);
        tick();
        i_ex_branch_taken = 1'b0;
        check("frz_after_ex", o_ex_valid, 1'b0);
        check("frz_after_wb", o_wb_valid, 1'b1);
        idle();
        tick();

        // Invalid opcode: one-cycle illegal pulse, controls all 0.
        id(ILL, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        check("ill_pulse", o_illegal, 1'b1);
        check("ill_ctrl", {o_ex_alusrc, o_ex_branch, o_ex_bne, o_ex_aluop}, 5'd0);
        tick();
        check("ill_pulse_end", o_illegal, 1'b0);
        check("ill_mem_ctrl", {o_mem_read, o_mem_write}, 2'd0);

        // Five more load-use stalls: 16-bit count reaches 6, 2-bit saturates at 3.
        for (int k = 0; k < 5; k++) begin
            id(LW, 5'd0, 5'd5, 5'd0);
            tick();
            id(RT, 5'd5, 5'd0, 5'd9);
            tick();
            tick();
        end
        idle();
        check("sat_count16", o_stall_count, 16'd6);
        check("sat_count2", s_stall_count, 2'd3);

        // Reset asserted in the middle of a freeze.
        id(SW, 5'd1, 5'd2, 5'd0);
        tick();
        idle();
        tick();
        i_mem_ready = 1'b0;
        tick();
        check("rst_frz_before", o_pc_stall, 1'b1);
        #2 d_rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_freeze");
        tick();
        i_mem_ready = 1'b1;
        d_rst_n = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
